// File: rtl/wb_pkg.sv
// Shared widths and the queued-write entry type for the writeback queue.
package wb_pkg;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int NREGS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Producer / register-file / decode signals of the writeback queue.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_queue_if;
  import wb_pkg::*;

  logic             aluValid;
  logic [AW-1:0]    aluAddr;
  logic [DW-1:0]    aluData;
  logic             memValid;
  logic [AW-1:0]    memAddr;
  logic [DW-1:0]    memData;
  logic             stall;
  logic             overflow;
  logic             regwrite;
  logic [AW-1:0]    wrAddr;
  logic [DW-1:0]    wrData;
  logic [NREGS-1:0] busy;
`ifdef WB_FWD_EN
  logic [AW-1:0]    rdAddrA, rdAddrB;
  logic             fwdHitA, fwdHitB;
  logic [DW-1:0]    fwdDataA, fwdDataB;
`endif

  modport slave (
    input  aluValid, aluAddr, aluData, memValid, memAddr, memData,
    output stall, overflow, regwrite, wrAddr, wrData, busy
`ifdef WB_FWD_EN
    , input rdAddrA, rdAddrB
    , output fwdHitA, fwdHitB, fwdDataA, fwdDataB
`endif
  );

  modport master (
    output aluValid, aluAddr, aluData, memValid, memAddr, memData,
    input  stall, overflow, regwrite, wrAddr, wrData, busy
`ifdef WB_FWD_EN
    , output rdAddrA, rdAddrB
    , input fwdHitA, fwdHitB, fwdDataA, fwdDataB
`endif
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular entry store: two ordered pushes (a older than b), one pop per cycle
// whenever non-empty. Caller guarantees pushes never exceed free space.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_a_i,
  input  wb_entry_t              entry_a_i,
  input  logic                   push_b_i,
  input  wb_entry_t              entry_b_i,
  output logic                   pop_o,
  output wb_entry_t              head_o,
  output logic [CW-1:0]          count_o
`ifdef WB_FWD_EN
  , output wb_entry_t [DEPTH-1:0] ents_o
  , output logic [PW-1:0]         head_ptr_o
`endif
);
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  assign pop_o   = (count_q != '0);
  assign head_o  = pop_o ? mem_q[head_q] : '0;
  assign count_o = count_q;
`ifdef WB_FWD_EN
  assign ents_o     = mem_q;
  assign head_ptr_o = head_q;
`endif

  always_comb begin
    head_d  = head_q + PW'(pop_o);
    tail_d  = tail_q + PW'(push_a_i) + PW'(push_b_i);
    count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // b lands behind a when both push; alone it takes the tail slot.
  always_ff @(posedge clk) begin
    if (push_a_i) mem_q[tail_q] <= entry_a_i;
    if (push_b_i) mem_q[tail_q + PW'(push_a_i)] <= entry_b_i;
  end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue: merges mem/ALU writes into the single register-file port,
// tracks per-register pending writes. Optional forwarding under WB_FWD_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic       clk,
  input  logic       rst,
  wb_queue_if.slave  bus
);
  logic          pop, mem_acc, alu_acc;
  logic [CW-1:0] count;
  logic [CW:0]   avail;
  wb_entry_t     head, mem_ent, alu_ent;
  logic          overflow_q, overflow_d;
  logic [NREGS-1:0][CW-1:0] bcnt_q, bcnt_d;
`ifdef WB_FWD_EN
  wb_entry_t [DEPTH-1:0] ents;
  logic [PW-1:0] head_ptr, idx;
`endif

  assign mem_ent = '{addr: bus.memAddr, data: bus.memData};
  assign alu_ent = '{addr: bus.aluAddr, data: bus.aluData};

  // Slots free this cycle include the one the head is vacating.
  always_comb begin
    avail   = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    mem_acc = bus.memValid && (avail != '0);
    alu_acc = bus.aluValid && (avail > (CW+1)'(mem_acc));
    overflow_d = overflow_q | (bus.memValid & ~mem_acc) | (bus.aluValid & ~alu_acc);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_a_i  (mem_acc),
    .entry_a_i (mem_ent),
    .push_b_i  (alu_acc),
    .entry_b_i (alu_ent),
    .pop_o     (pop),
    .head_o    (head),
    .count_o   (count)
`ifdef WB_FWD_EN
    , .ents_o     (ents)
    , .head_ptr_o (head_ptr)
`endif
  );

  assign bus.regwrite = pop && !rst;
  assign bus.wrAddr   = head.addr;
  assign bus.wrData   = head.data;
  assign bus.stall    = (count >= CW'(DEPTH - 1));
  assign bus.overflow = overflow_q;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      bcnt_d[r] = bcnt_q[r]
                + CW'(mem_acc && (bus.memAddr == AW'(r)))
                + CW'(alu_acc && (bus.aluAddr == AW'(r)))
                - CW'(pop && (head.addr == AW'(r)));
      bus.busy[r] = (bcnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      bcnt_q     <= bcnt_d;
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    idx          = '0;
    bus.fwdHitA  = 1'b0;
    bus.fwdHitB  = 1'b0;
    bus.fwdDataA = '0;
    bus.fwdDataB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (ents[idx].addr == bus.rdAddrA) begin
          bus.fwdHitA  = 1'b1;
          bus.fwdDataA = ents[idx].data;
        end
        if (ents[idx].addr == bus.rdAddrB) begin
          bus.fwdHitB  = 1'b1;
          bus.fwdDataB = ents[idx].data;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4); forwarding checks when WB_FWD_EN is set.
module tb_wb_queue;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  wb_queue_if bus();
  wb_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bus.memValid = mv; bus.memAddr = ma; bus.memData = md;
    bus.aluValid = av; bus.aluAddr = aa; bus.aluData = ad;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_out(input string tag, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NREGS-1:0] b);
    chk({tag, ".regwrite"}, 32'(bus.regwrite), 32'(rw));
    chk({tag, ".wrAddr"},   32'(bus.wrAddr),   32'(a));
    chk({tag, ".wrData"},   32'(bus.wrData),   32'(d));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
  endtask

  initial begin
    idle();
`ifdef WB_FWD_EN
    bus.rdAddrA = 3'd1;
    bus.rdAddrB = 3'd2;
`endif
    step(); step();
    chk("rst.regwrite_in_reset", 32'(bus.regwrite), 32'd0);
    rst = 1'b0;
    chk("rst.stall", 32'(bus.stall), 32'd0);
    chk("rst.overflow", 32'(bus.overflow), 32'd0);
    chk_out("rst", 1'b0, 3'd0, 8'd0, 8'h00);

    // Single ALU write r3 <- 12
    drive(1'b0, '0, '0, 1'b1, 3'd3, 8'd12);
    step(); idle();
    chk_out("alu1", 1'b1, 3'd3, 8'd12, 8'h08);
    step();
    chk_out("alu1.done", 1'b0, 3'd0, 8'd0, 8'h00);

    // mem r1<-5 and ALU r1<-9 together: mem drains first
    drive(1'b1, 3'd1, 8'd5, 1'b1, 3'd1, 8'd9);
    step(); idle();
    chk_out("dual.c1", 1'b1, 3'd1, 8'd5, 8'h02);
`ifdef WB_FWD_EN
    chk("fwd.hitA.both", 32'(bus.fwdHitA), 32'd1);
    chk("fwd.dataA.both", 32'(bus.fwdDataA), 32'd9);
    chk("fwd.hitB.miss", 32'(bus.fwdHitB), 32'd0);
`endif
    step();
    chk_out("dual.c2", 1'b1, 3'd1, 8'd9, 8'h02);
`ifdef WB_FWD_EN
    chk("fwd.dataA.one", 32'(bus.fwdDataA), 32'd9);
`endif
    step();
    chk_out("dual.done", 1'b0, 3'd0, 8'd0, 8'h00);
`ifdef WB_FWD_EN
    chk("fwd.hitA.empty", 32'(bus.fwdHitA), 32'd0);
`endif

    // Fill: two pushes per cycle, then one push pair while full
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    step();
    chk("fill.c1.stall", 32'(bus.stall), 32'd0);
    chk_out("fill.c1", 1'b1, 3'd1, 8'h11, 8'h06);
    drive(1'b1, 3'd3, 8'h33, 1'b1, 3'd4, 8'h44);
    step();
    chk("fill.c2.stall", 32'(bus.stall), 32'd1);
    chk_out("fill.c2", 1'b1, 3'd2, 8'h22, 8'h1C);
    drive(1'b1, 3'd5, 8'h55, 1'b1, 3'd6, 8'h66);
    step();
    chk("fill.c3.stall", 32'(bus.stall), 32'd1);
    chk("fill.c3.overflow", 32'(bus.overflow), 32'd0);
    chk_out("fill.c3", 1'b1, 3'd3, 8'h33, 8'h78);
    drive(1'b1, 3'd7, 8'h77, 1'b1, 3'd0, 8'h0A);
    step(); idle();
    chk("full.overflow", 32'(bus.overflow), 32'd1);
    chk("full.stall", 32'(bus.stall), 32'd1);
    chk_out("full", 1'b1, 3'd4, 8'h44, 8'hF0);
    step();
    chk_out("drain1", 1'b1, 3'd5, 8'h55, 8'hE0);
    step();
    chk("drain2.stall", 32'(bus.stall), 32'd0);
    chk_out("drain2", 1'b1, 3'd6, 8'h66, 8'hC0);
    step();
    chk_out("drain3", 1'b1, 3'd7, 8'h77, 8'h80);
    step();
    chk_out("drain.done", 1'b0, 3'd0, 8'd0, 8'h00);
    chk("drain.overflow_sticky", 32'(bus.overflow), 32'd1);

    // Reset with three entries pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.overflow", 32'(bus.overflow), 32'd0);
    drive(1'b1, 3'd1, 8'd1, 1'b1, 3'd2, 8'd2);
    step();
    drive(1'b1, 3'd3, 8'd3, 1'b1, 3'd4, 8'd4);
    step(); idle();
    chk("pend.stall", 32'(bus.stall), 32'd1);
    chk("pend.busy", 32'(bus.busy), 32'h1C);
    rst = 1'b1;
    #1;
    chk("mid.regwrite_in_reset", 32'(bus.regwrite), 32'd0);
    step();
    rst = 1'b0;
    chk("mid.stall", 32'(bus.stall), 32'd0);
    chk("mid.overflow", 32'(bus.overflow), 32'd0);
    chk_out("mid.after", 1'b0, 3'd0, 8'd0, 8'h00);
    step();
    chk_out("mid.after2", 1'b0, 3'd0, 8'd0, 8'h00);

    // Streaming single ALU pushes: steady count of one
    for (int r = 2; r < 8; r++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(r), DW'(r * 3));
      step();
      chk("stream.stall", 32'(bus.stall), 32'd0);
      chk_out("stream", 1'b1, AW'(r), DW'(r * 3), NREGS'(1 << r));
    end
    idle();
    step();
    chk_out("stream.done", 1'b0, 3'd0, 8'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue sitting directly upstream of the 8×8-bit register file. Merges result writes from the single-cycle ALU and the multi-cycle memory/load unit, which can finish in the same cycle, into the register file's single write port (`regwrite`/`wrAddr`/`wrData`). Buffers up to DEPTH pending writes, back-pressures producers, and exports per-register pending-write (busy) bits for decode hazard checks.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `AW`, 3, register address width (8 registers)
- `DW`, 8, data width
- `clk` in 1: the only clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `aluValid` in 1: ALU write request this cycle
- `aluAddr` in AW: ALU destination register
- `aluData` in DW: ALU result
- `memValid` in 1: load write request this cycle
- `memAddr` in AW: load destination register
- `memData` in DW: load data
- `stall` out 1: producers must not assert valid while high
- `overflow` out 1: sticky; a request arrived with no free slot
- `regwrite` out 1: register file write enable
- `wrAddr` out AW: register file write address
- `wrData` out DW: register file write data
- `busy` out 2^AW: bit r high while any queued entry targets register r
- `rdAddrA`, `rdAddrB` in AW: decode read addresses (forwarding lookup)
- `fwdHitA`, `fwdHitB` out 1: a queued entry targets rdAddrA/B (WB_FWD_EN only)
- `fwdDataA`, `fwdDataB` out DW: data of youngest matching entry (WB_FWD_EN only)

## Operation
- Circular FIFO: head pointer, tail pointer, count of width log2(DEPTH)+1.
- Push order within one cycle: mem entry first (older), then ALU entry. Up to 2 pushes per cycle.
- Pop: exactly one entry per cycle whenever count > 0. Head drives `regwrite`=1, `wrAddr`, `wrData` combinationally; entry retires at the same posedge the register file writes it.
- next count = count + pushes − pop; push and pop in the same cycle are always legal.
- `stall` = (count ≥ DEPTH−1), combinational from registered count.
- Push with no free slot (after accounting for the same-cycle pop and earlier push): that request is dropped and `overflow` sets; it clears only on reset. The mem request is accepted before the ALU request.
- Busy: one pending counter per register (width log2(DEPTH)+1): increment on accepted push, decrement on pop; `busy[r]` = counter≠0. Push and pop to the same register in one cycle leave the counter unchanged.
- Writes to register 0 are queued like any other write; no special case.
- Outputs when empty: `regwrite`=0; `wrAddr`, `wrData`=0.

## Timing
- Latency: request accepted at edge N → on `wrAddr`/`wrData` in cycle N+1 if queue was empty → written into the register file at edge N+1.
- Two simultaneous requests into an empty queue: mem written at edge N+1, ALU at edge N+2.
- `busy[r]` rises the cycle after the accepting edge and falls the cycle after the retiring edge.
- Reset (any cycle, including mid-drain): `regwrite` forced 0 while `rst` high; at the edge, pointers, count, busy counters and `overflow` clear; pending entries discarded. After reset: `stall`=0, `overflow`=0, `busy`=0, `regwrite`=0.

## Configuration
- `WB_FWD_EN` defined: `fwdHit*`/`fwdData*` present. Hit is combinational over all valid entries; data is from the youngest match (an ALU push is younger than a mem push from the same cycle). Entries pushed in the current cycle are not visible until the next cycle.
- Not defined: forwarding ports and logic absent; decode must stall on `busy`.

## Structure
- Package `wb_pkg`: AW, DW, NREGS=2^AW, and a packed entry typedef {addr, data}.
- Sub-module `wb_fifo`: entry storage, pointers, count, dual push / single pop. `wb_queue` wraps it and adds stall/overflow, the busy scoreboard and forwarding.

## Test plan
- Single ALU write r3←12 into empty queue → next cycle `regwrite`=1, `wrAddr`=3, `wrData`=12; `busy[3]`=1 for exactly one cycle.
- Simultaneous mem r1←5 and ALU r1←9 → r1 written 5 then 9 on consecutive cycles; `busy[1]` high 2 cycles; with WB_FWD_EN and `rdAddrA`=1, `fwdDataA`=9 while both are queued.
- Two pushes per cycle for 3 cycles (DEPTH=4) → `stall` high once count≥3; a further push while full → dropped, `overflow`=1 stays set.
- Reset asserted with 3 entries pending → `regwrite`=0 during the reset cycle; afterwards count=0, `busy`=0, no write emitted.
- Continuous single ALU push each cycle to r2, r3, r4, … → steady count=1, `stall` never asserted, writes emitted in order with 1-cycle latency.
